// File: rtl/pcbt_group_sender.sv
// pcbt_group_sender: buffers float words from an upstream producer and
// streams them to the pcbt accumulator in groups of a given length,
// flagging the last word of each group with end_of_group.
module pcbt_group_sender #(
  parameter int unsigned width      = 32,
  parameter int unsigned depth      = 16,
  parameter int unsigned max_inputs = 32768,
  localparam int unsigned len_w     = $clog2(max_inputs) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [width-1:0]  data_in,
  input  logic              data_wr,
  output logic              data_full,
  input  logic [len_w-1:0]  grp_len,
  input  logic              grp_valid,
  output logic              grp_ready,
  output logic [width-1:0]  ip,
  output logic              valid_in,
  output logic              end_of_group,
  input  logic              ready,
  output logic              overflow,
  output logic              len_err,
  output logic [15:0]       groups_sent
);

  localparam int unsigned ptr_w = $clog2(depth);
  localparam int unsigned cnt_w = ptr_w + 1;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t state, next_state;

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [cnt_w-1:0] count;
  logic [cnt_w-1:0] count_next;

  logic [len_w-1:0] remaining;

  logic push;
  logic pop;
  logic accept;
  logic len_ok;
  logic last_word;

  // A write is taken only when there is room; full is the registered flag.
  assign push = data_wr && !data_full;

  // Descriptor lengths outside 1..max_inputs are accepted but rejected.
  assign len_ok = (grp_len != '0) && (grp_len <= len_w'(max_inputs));

  assign last_word = (remaining == len_w'(1));

  // Show-ahead: head of the FIFO drives ip straight from the memory.
  assign ip = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + cnt_w'(1);
      2'b01:   count_next = count - cnt_w'(1);
      default: count_next = count;
    endcase
  end

  // FIFO storage; memory itself needs no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers, occupancy, full flag and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptr_w'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_w'(1);
      end
      count     <= count_next;
      data_full <= (count_next == cnt_w'(depth));
      // A dropped write counts even when a pop frees a slot in the same cycle.
      if (data_wr && data_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    next_state   = state;
    grp_ready    = 1'b0;
    valid_in     = 1'b0;
    end_of_group = 1'b0;
    accept       = 1'b0;
    pop          = 1'b0;
    unique case (state)
      IDLE: begin
        grp_ready = !rst;
        if (grp_valid && !rst) begin
          accept = 1'b1;
          if (len_ok) begin
            next_state = STREAM;
          end
        end
      end
      STREAM: begin
        valid_in     = (count != '0);
        end_of_group = valid_in && last_word;
        pop          = valid_in && ready;
        if (pop && last_word) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Group bookkeeping: words left in the group, completed count, length error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining   <= '0;
      groups_sent <= '0;
      len_err     <= 1'b0;
    end else begin
      len_err <= accept && !len_ok;
      if (accept && len_ok) begin
        remaining <= grp_len;
      end else if (pop) begin
        remaining <= remaining - len_w'(1);
      end
      if (pop && last_word) begin
        groups_sent <= groups_sent + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pcbt_group_sender.sv
// Directed bench for pcbt_group_sender: checks reset state, single and
// back-pressured groups, FIFO full/overflow, length errors, reset mid-group
// and a short mixed soak against a word/flag scoreboard.
module tb_pcbt_group_sender;

  localparam int unsigned width = 32;
  localparam int unsigned len_w = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [width-1:0]  data_in = '0;
  logic              data_wr = 1'b0;
  logic              data_full;
  logic [len_w-1:0]  grp_len = '0;
  logic              grp_valid = 1'b0;
  logic              grp_ready;
  logic [width-1:0]  ip;
  logic              valid_in;
  logic              end_of_group;
  logic              ready = 1'b0;
  logic              overflow;
  logic              len_err;
  logic [15:0]       groups_sent;

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0] cap [$];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_ip = '0;
  logic        prev_eog = 1'b0;
  logic        soak_done = 1'b0;

  pcbt_group_sender #(
    .width(32),
    .depth(16),
    .max_inputs(32768)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_wr(data_wr),
    .data_full(data_full),
    .grp_len(grp_len),
    .grp_valid(grp_valid),
    .grp_ready(grp_ready),
    .ip(ip),
    .valid_in(valid_in),
    .end_of_group(end_of_group),
    .ready(ready),
    .overflow(overflow),
    .len_err(len_err),
    .groups_sent(groups_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] w);
    data_wr = 1'b1;
    data_in = w;
    tick();
    data_wr = 1'b0;
  endtask

  task automatic send_desc(input logic [15:0] len);
    int n = 0;
    while (!grp_ready && n < 3000) begin
      tick();
      n++;
    end
    if (!grp_ready) check("desc_timeout", 0, 1);
    grp_valid = 1'b1;
    grp_len   = len;
    tick();
    grp_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!grp_ready && n < 3000) begin
      tick();
      n++;
    end
    check("idle_timeout", grp_ready, 1);
  endtask

  // Transfers are captured at negedge, where inputs and outputs are settled for the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", valid_in, 1);
        check("hold_ip", ip, prev_ip);
        check("hold_eog", end_of_group, prev_eog);
      end
      if (valid_in && ready) cap.push_back({end_of_group, ip});
      prev_hold = valid_in && !ready;
      prev_ip   = ip;
      prev_eog  = end_of_group;
    end
  end

  logic [31:0] exp_w [$];
  logic        exp_e [$];
  int          lens [6];

  initial begin
    logic [31:0] fives [5];
    logic [7:0]  pat;
    fives = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    pat   = 8'b11011001; // bit i is ready in cycle i: 1,0,0,1,1,0,1,1

    // Reset state
    tick();
    check("rst_grp_ready", grp_ready, 0);
    check("rst_full", data_full, 0);
    check("rst_valid", valid_in, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_grp_ready", grp_ready, 1);
    check("post_rst_overflow", overflow, 0);
    check("post_rst_len_err", len_err, 0);
    check("post_rst_groups", groups_sent, 0);
    check("post_rst_eog", end_of_group, 0);

    // Single-word group
    write_word(32'h3F800000);
    ready = 1'b1;
    send_desc(16'd1);
    check("t1_valid", valid_in, 1);
    check("t1_eog", end_of_group, 1);
    check("t1_ip", ip, 32'h3F800000);
    check("t1_grp_ready_busy", grp_ready, 0);
    tick();
    check("t1_groups", groups_sent, 1);
    check("t1_grp_ready", grp_ready, 1);
    check("t1_valid_off", valid_in, 0);
    check("t1_ncap", cap.size(), 1);
    cap.delete();

    // Back-pressure
    ready = 1'b0;
    for (int i = 0; i < 5; i++) write_word(fives[i]);
    send_desc(16'd5);
    for (int i = 0; i < 8; i++) begin
      ready = pat[i];
      tick();
    end
    ready = 1'b1;
    check("t2_ncap", cap.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < cap.size()) begin
        check($sformatf("t2_word%0d", i), cap[i][31:0], fives[i]);
        check($sformatf("t2_eog%0d", i), cap[i][32], (i == 4) ? 1 : 0);
      end
    end
    check("t2_groups", groups_sent, 2);
    check("t2_grp_ready", grp_ready, 1);
    cap.delete();

    // FIFO full / overflow
    for (int i = 0; i < 16; i++) write_word(32'h100 + i);
    check("t3_full", data_full, 1);
    check("t3_no_ovf_yet", overflow, 0);
    write_word(32'hDEAD);
    check("t3_ovf", overflow, 1);
    send_desc(16'd16);
    wait_idle();
    check("t3_ncap", cap.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < cap.size()) check($sformatf("t3_word%0d", i), cap[i][31:0], 32'h100 + i);
    end
    check("t3_not_full", data_full, 0);
    check("t3_groups", groups_sent, 3);
    tick();
    check("t3_empty_after", valid_in, 0);
    cap.delete();

    // Length errors
    send_desc(16'd0);
    check("t4_err0", len_err, 1);
    check("t4_idle0", grp_ready, 1);
    check("t4_novalid0", valid_in, 0);
    tick();
    check("t4_err0_clear", len_err, 0);
    send_desc(16'd32769);
    check("t4_err_big", len_err, 1);
    check("t4_idle_big", grp_ready, 1);
    tick();
    check("t4_err_big_clear", len_err, 0);
    check("t4_groups", groups_sent, 3);
    check("t4_ncap", cap.size(), 0);

    // Reset mid-group
    for (int i = 0; i < 10; i++) write_word(32'h200 + i);
    send_desc(16'd10);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("t5_valid_rst", valid_in, 0);
    check("t5_groups_rst", groups_sent, 0);
    check("t5_ovf_rst", overflow, 0);
    check("t5_grp_ready_rst", grp_ready, 0);
    rst = 1'b0;
    tick();
    check("t5_grp_ready", grp_ready, 1);
    check("t5_ncap4", cap.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < cap.size()) begin
        check($sformatf("t5_word%0d", i), cap[i][31:0], 32'h200 + i);
        check($sformatf("t5_eog%0d", i), cap[i][32], 0);
      end
    end
    cap.delete();
    send_desc(16'd3);
    tick();
    check("t5_fifo_empty", valid_in, 0);
    write_word(32'h300);
    check("t5_latency", valid_in, 1);
    write_word(32'h301);
    write_word(32'h302);
    wait_idle();
    check("t5_ncap3", cap.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < cap.size()) begin
        check($sformatf("t5b_word%0d", i), cap[i][31:0], 32'h300 + i);
        check($sformatf("t5b_eog%0d", i), cap[i][32], (i == 2) ? 1 : 0);
      end
    end
    check("t5_groups", groups_sent, 1);
    cap.delete();

    // Soak: concurrent producer, descriptors and random back-pressure
    for (int g = 0; g < 6; g++) begin
      lens[g] = $urandom_range(1, 40);
      for (int k = 0; k < lens[g]; k++) begin
        exp_w.push_back($urandom);
        exp_e.push_back(k == lens[g] - 1);
      end
    end
    fork
      begin
        for (int k = 0; k < exp_w.size(); k++) begin
          int n = 0;
          while (data_full && n < 3000) begin
            tick();
            n++;
          end
          write_word(exp_w[k]);
        end
      end
      begin
        int n = 0;
        for (int g = 0; g < 6; g++) send_desc(lens[g][15:0]);
        while (groups_sent != 16'd7 && n < 5000) begin
          tick();
          n++;
        end
        check("soak_groups", groups_sent, 7);
        soak_done = 1'b1;
      end
      begin
        int n = 0;
        while (!soak_done && n < 20000) begin
          ready = 1'($urandom_range(0, 1));
          tick();
          n++;
        end
        ready = 1'b1;
      end
    join
    check("soak_ncap", cap.size(), exp_w.size());
    for (int k = 0; k < exp_w.size(); k++) begin
      if (k < cap.size()) begin
        check($sformatf("soak_word%0d", k), cap[k][31:0], exp_w[k]);
        check($sformatf("soak_eog%0d", k), cap[k][32], exp_e[k]);
      end
    end
    check("soak_overflow", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
